// File: rtl/mem_copy_engine.sv
// ============================================================================
// mem_copy_engine: copies len words src -> dst through the memory data port.
// Optional feature macro: COPY_CHECKSUM_EN (adds checksum port/accumulator).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 512,
    parameter int LENW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [LENW-1:0]  len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(RAMSIZE * 6);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  i_q, i_d;
    logic [WIDTH-1:0] mem_a_q, mem_a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   src_end, dst_end;

    // One extra bit so an address near the top of the space cannot wrap past the limit
    assign src_end = {1'b0, src_q} + (WIDTH+1)'(len_q);
    assign dst_end = {1'b0, dst_q} + (WIDTH+1)'(len_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        mem_a_d = mem_a_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    i_d     = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_q == '0) begin
                    state_d = S_FIN;
                end else if ((src_end > LIMIT) || (dst_end > LIMIT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_a_d = src_q;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                mem_a_d = dst_q + WIDTH'(i_q);
                state_d = S_WR;
            end
            S_WR: begin
                i_d = i_q + 1'b1;
                if (i_d < len_q) begin
                    mem_a_d = src_q + WIDTH'(i_d);
                    state_d = S_RD;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            mem_a_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            mem_a_q <= mem_a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Write strobe and data decode straight from state so reset kills them at once
    assign mem_we = (state_q == S_WR);
    assign mem_wd = mem_we ? mem_rd : '0;
    assign mem_a  = mem_a_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

`ifdef COPY_CHECKSUM_EN
    logic [WIDTH-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if ((state_q == S_IDLE) && start) begin
            chk_d = '0;
        end else if (state_q == S_WR) begin
            chk_d = chk_q + mem_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// tb_mem_copy_engine: directed self-checking bench with a 6*RAMSIZE word memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    localparam int WIDTH = 32;
    localparam int LENW  = 12;
    localparam int WORDS = 3072;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] src, dst;
    logic [LENW-1:0]  len;
    logic             busy, done, err, mem_we;
    logic [WIDTH-1:0] mem_a, mem_wd, mem_rd;
`ifdef COPY_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_copy_engine #(.WIDTH(WIDTH), .RAMSIZE(512), .LENW(LENW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
`ifdef COPY_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, write on mem_we, plus a bench preload port
    logic [WIDTH-1:0] mem [0:WORDS-1];
    logic             pk_en;
    logic [WIDTH-1:0] pk_a, pk_d;

    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        else if (mem_we && mem_a < WORDS) mem[mem_a] <= mem_wd;
        mem_rd <= (mem_a < WORDS) ? mem[mem_a] : '0;
    end

    task automatic poke(input int a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // Issue one command and wait (bounded) for done or err; cycle n counts edges after acceptance
    task automatic run_cmd(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d,
                           input logic [LENW-1:0] l, output int cyc, output bit got_done,
                           output bit got_err, output bit busy_end, output bit busy0,
                           output int wes);
        cyc = -1; got_done = 0; got_err = 0; busy_end = 1; wes = 0;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (done || err) begin
                cyc = n; got_done = done; got_err = err; busy_end = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0h want 0", done); end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0h want 0", err); end
        n_cmp++;
        if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0h want 0", mem_we); end
        n_cmp++;
        if (mem_a !== '0) begin n_bad++; $display("FAIL reset_a got %0h want 0", mem_a); end
        n_cmp++;
        if (mem_wd !== '0) begin n_bad++; $display("FAIL reset_wd got %0h want 0", mem_wd); end
        n_cmp++;
`ifdef COPY_CHECKSUM_EN
        if (checksum !== '0) begin n_bad++; $display("FAIL reset_chk got %0h want 0", checksum); end
        n_cmp++;
`endif
    endtask

    task automatic test_basic();
        int cyc, wes; bit dn, er, be, b0;
        for (int k = 0; k < 4; k++) poke(k, k + 1);
        for (int k = 100; k < 104; k++) poke(k, 32'hDEAD);
        run_cmd(0, 100, 4, cyc, dn, er, be, b0, wes);
        if (cyc !== 10) begin n_bad++; $display("FAIL basic_cycle got %0d want 10", cyc); end
        n_cmp++;
        if (er !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0h want 0", er); end
        n_cmp++;
        if (b0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start got %0h want 1", b0); end
        n_cmp++;
        if (be !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done got %0h want 0", be); end
        n_cmp++;
        if (wes !== 4) begin n_bad++; $display("FAIL basic_writes got %0d want 4", wes); end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            if (mem[100+k] !== k + 1) begin
                n_bad++; $display("FAIL basic_mem%0d got %0h want %0h", 100 + k, mem[100+k], k + 1);
            end
            n_cmp++;
        end
`ifdef COPY_CHECKSUM_EN
        if (checksum !== 32'd10) begin n_bad++; $display("FAIL basic_chk got %0d want 10", checksum); end
        n_cmp++;
`endif
    endtask

    task automatic test_len_zero_and_range();
        int cyc, wes; bit dn, er, be, b0;
        run_cmd(5, 200, 0, cyc, dn, er, be, b0, wes);
        if (cyc !== 2 || dn !== 1'b1 || er !== 1'b0) begin
            n_bad++; $display("FAIL len0 got cyc=%0d done=%0h err=%0h want cyc=2 done=1 err=0", cyc, dn, er);
        end
        n_cmp++;
        if (wes !== 0) begin n_bad++; $display("FAIL len0_writes got %0d want 0", wes); end
        n_cmp++;
        poke(0, 32'h1234);
        run_cmd(3000, 0, 100, cyc, dn, er, be, b0, wes);
        if (cyc !== 1 || er !== 1'b1 || dn !== 1'b0) begin
            n_bad++; $display("FAIL range_err got cyc=%0d done=%0h err=%0h want cyc=1 done=0 err=1", cyc, dn, er);
        end
        n_cmp++;
        if (wes !== 0 || mem[0] !== 32'h1234) begin
            n_bad++; $display("FAIL range_untouched got wes=%0d mem0=%0h want 0 1234", wes, mem[0]);
        end
        n_cmp++;
    endtask

    task automatic test_overlap();
        int cyc, wes; bit dn, er, be, b0;
        poke(10, 7);
        for (int k = 11; k < 14; k++) poke(k, 99);
        run_cmd(10, 11, 3, cyc, dn, er, be, b0, wes);
        if (cyc !== 8) begin n_bad++; $display("FAIL overlap_cycle got %0d want 8", cyc); end
        n_cmp++;
        for (int k = 11; k < 14; k++) begin
            if (mem[k] !== 7) begin n_bad++; $display("FAIL overlap_mem%0d got %0h want 7", k, mem[k]); end
            n_cmp++;
        end
`ifdef COPY_CHECKSUM_EN
        if (checksum !== 32'd21) begin n_bad++; $display("FAIL overlap_chk got %0d want 21", checksum); end
        n_cmp++;
`endif
    endtask

    task automatic test_busy_ignore();
        int dones, done_at;
        poke(20, 5); poke(21, 6); poke(22, 7);
        for (int k = 40; k < 43; k++) poke(k, 0);
        for (int k = 60; k < 63; k++) poke(k, 0);
        dones = 0; done_at = -1;
        @(negedge clk);
        start = 1'b1; src = 20; dst = 40; len = 3;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done) begin dones++; done_at = n; end
            start = (n == 3);
            src = 0; dst = 60; len = 3;
        end
        start = 1'b0;
        if (dones !== 1 || done_at !== 8) begin
            n_bad++; $display("FAIL ignore_done got count=%0d at=%0d want 1 at 8", dones, done_at);
        end
        n_cmp++;
        if (mem[40] !== 5 || mem[41] !== 6 || mem[42] !== 7) begin
            n_bad++; $display("FAIL ignore_data got %0h %0h %0h want 5 6 7", mem[40], mem[41], mem[42]);
        end
        n_cmp++;
        if (mem[60] !== 0) begin n_bad++; $display("FAIL ignore_second got %0h want 0", mem[60]); end
        n_cmp++;
    endtask

    task automatic test_reset_mid_copy();
        for (int k = 0; k < 8; k++) poke(200 + k, 32'hA0 + k);
        for (int k = 0; k < 8; k++) poke(300 + k, 0);
        @(negedge clk);
        start = 1'b1; src = 200; dst = 300; len = 8;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we got %0h want 1", mem_we); end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid got we=%0h busy=%0h done=%0h err=%0h want 0 0 0 0",
                              mem_we, busy, done, err);
        end
        n_cmp++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (mem[300] !== 32'hA0 || mem[301] !== 32'hA1 || mem[302] !== 0) begin
            n_bad++; $display("FAIL rst_partial got %0h %0h %0h want a0 a1 0", mem[300], mem[301], mem[302]);
        end
        n_cmp++;
    endtask

    task automatic test_boundary();
        int cyc, wes; bit dn, er, be, b0;
        run_cmd(32'hFFFF_FFFF, 0, 2, cyc, dn, er, be, b0, wes);
        if (cyc !== 1 || er !== 1'b1 || wes !== 0) begin
            n_bad++; $display("FAIL wrap_err got cyc=%0d err=%0h wes=%0d want 1 1 0", cyc, er, wes);
        end
        n_cmp++;
        poke(0, 32'h55); poke(1, 32'h66); poke(3070, 0); poke(3071, 0);
        run_cmd(0, 3070, 2, cyc, dn, er, be, b0, wes);
        if (cyc !== 6 || dn !== 1'b1 || er !== 1'b0) begin
            n_bad++; $display("FAIL top_done got cyc=%0d done=%0h err=%0h want 6 1 0", cyc, dn, er);
        end
        n_cmp++;
        if (mem[3070] !== 32'h55 || mem[3071] !== 32'h66) begin
            n_bad++; $display("FAIL top_mem got %0h %0h want 55 66", mem[3070], mem[3071]);
        end
        n_cmp++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        pk_en = 1'b0; pk_a = '0; pk_d = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_len_zero_and_range();
        test_overlap();
        test_busy_ignore();
        test_reset_mid_copy();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
